// File: rtl/des_pkg.sv
// Shared DES key-schedule tables, FSM state type and widths for the round controller.
package des_pkg;

    localparam int KEY_W    = 64;
    localparam int CD_W     = 56;
    localparam int RK_W     = 48;
    localparam int N_ROUNDS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int SHIFT_TBL [N_ROUNDS] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Tables use DES bit numbering: entry value 1 is the MSB of the source vector.
    localparam int PC1_TBL [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TBL [RK_W] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] key);
        logic [CD_W-1:0] cd;
        cd = '0;
        for (int i = 0; i < CD_W; i++) begin
            cd[CD_W-1-i] = key[KEY_W-PC1_TBL[i]];
        end
        return cd;
    endfunction

    function automatic logic [RK_W-1:0] pc2(input logic [CD_W-1:0] cd);
        logic [RK_W-1:0] rk;
        rk = '0;
        for (int i = 0; i < RK_W; i++) begin
            rk[RK_W-1-i] = cd[CD_W-PC2_TBL[i]];
        end
        return rk;
    endfunction

    function automatic logic [27:0] rot_half(input logic [27:0] x, input logic right, input logic two);
        logic [27:0] y;
        case ({right, two})
            2'b00:   y = {x[26:0], x[27]};
            2'b01:   y = {x[25:0], x[27:26]};
            2'b10:   y = {x[0], x[27:1]};
            default: y = {x[1:0], x[27:2]};
        endcase
        return y;
    endfunction

    function automatic logic key_par_ok(input logic [KEY_W-1:0] key);
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < KEY_W / 8; b++) begin
            ok = ok & (^key[8*b +: 8]);
        end
        return ok;
    endfunction

endpackage

// File: rtl/des_key_sched.sv
// DES key schedule: CD register with per-round rotation and PC2 round-key output.
module des_key_sched
    import des_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             mode,
    input  logic [3:0]       rnd_idx,
    input  logic [KEY_W-1:0] key,
    output logic [RK_W-1:0]  rnd_key
);

    logic [CD_W-1:0] cd_q;
    logic [CD_W-1:0] cd_d;
    logic [CD_W-1:0] cd_key;
    logic [CD_W-1:0] cd_load;
    logic [3:0]      sh_idx;
    logic            two;

    assign cd_key = pc1(key);

    // Encrypt looks ahead to the next round's shift; decrypt undoes the shifts in reverse.
    assign sh_idx = mode ? (4'd15 - rnd_idx) : (rnd_idx + 4'd1);
    assign two    = (SHIFT_TBL[sh_idx] == 2);

    always_comb begin
        cd_load = cd_key;
        if (!mode) begin
            cd_load = {rot_half(cd_key[55:28], 1'b0, 1'b0), rot_half(cd_key[27:0], 1'b0, 1'b0)};
        end
    end

    always_comb begin
        cd_d = cd_q;
        if (load) begin
            cd_d = cd_load;
        end else if (step) begin
            cd_d = {rot_half(cd_q[55:28], mode, two), rot_half(cd_q[27:0], mode, two)};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cd_q <= '0;
        end else begin
            cd_q <= cd_d;
        end
    end

    assign rnd_key = pc2(cd_q);

endmodule

// File: rtl/des_round_ctrl.sv
// Iterative DES round sequencer: accepts key+mode, steps 16 rounds, holds result until consumed.
// Optional key parity rejection is enabled by defining DES_PAR_CHECK_EN.
//
//   state | meaning
//   IDLE  | waiting for a request, in_ready high
//   ROUND | datapath runs one round per cycle, rnd_idx 0..15
//   DONE  | result valid, waiting for out_ready
module des_round_ctrl #(
    parameter int KEY_W  = 64,
    parameter int RK_W   = 48,
    parameter int ROUNDS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [KEY_W-1:0] in_key,
    input  logic             in_mode,
    output logic             dp_load,
    output logic             rnd_en,
    output logic [3:0]       rnd_idx,
    output logic             rnd_last,
    output logic [RK_W-1:0]  rnd_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             key_err
);
    import des_pkg::*;

    if (KEY_W != 64 || RK_W != 48 || ROUNDS != 16) begin : g_bad_cfg
        $error("des_round_ctrl supports only KEY_W=64, RK_W=48, ROUNDS=16");
    end

    state_t     state_q;
    state_t     state_d;
    logic [3:0] idx_q;
    logic       mode_q;
    logic       par_ok;
    logic       accept;
    logic       last_rnd;
    logic       ks_mode;

`ifdef DES_PAR_CHECK_EN
    assign par_ok  = key_par_ok(in_key);
    assign key_err = in_valid && in_ready && !par_ok;
`else
    assign par_ok  = 1'b1;
    assign key_err = 1'b0;
`endif

    assign last_rnd = (idx_q == 4'(ROUNDS - 1));

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        rnd_en    = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid && par_ok;
                if (accept) state_d = ROUND;
            end
            ROUND: begin
                rnd_en = 1'b1;
                if (last_rnd) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dp_load  = accept;
    assign rnd_idx  = idx_q;
    assign rnd_last = rnd_en && last_rnd;

    // The counter only advances in ROUND, so it wraps to 0 on entering DONE and stays there.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) mode_q <= in_mode;
            if (rnd_en) idx_q <= idx_q + 4'd1;
        end
    end

    assign ks_mode = accept ? in_mode : mode_q;

    des_key_sched u_key_sched (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .step    (rnd_en && !last_rnd),
        .mode    (ks_mode),
        .rnd_idx (idx_q),
        .key     (in_key),
        .rnd_key (rnd_key)
    );

endmodule
